// File: rtl/subtrator_serial_pkg.sv
// Shared state encodings and FSM state type for the bit-serial subtractor.
// The guarded defines keep the raw encodings available to any file that needs them.
`ifndef SUBTRATOR_SERIAL_STATES
`define SUBTRATOR_SERIAL_STATES
`define SUB_IDLE 2'd0
`define SUB_RUN  2'd1
`define SUB_DONE 2'd2
`endif

package subtrator_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = `SUB_IDLE,
        ST_RUN  = `SUB_RUN,
        ST_DONE = `SUB_DONE
    } sub_state_t;

endpackage

// File: rtl/subtrator_completo.sv
// Single-bit full subtractor: diff = a - b - borrow_in, with borrow_out
// set when the bit has to borrow from the next higher position.
module subtrator_completo (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic borrow_out,
    output logic diff
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor: one full-subtractor cell, registered borrow,
// LSB-first shifting; result and flags are published only when the last bit is done.
module subtrator_serial
    import subtrator_serial_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         borrow_out,
    output logic         overflow,
    output logic         zero,
    output sub_state_t   state
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    sub_state_t    next_state;
    logic          load;
    logic          step;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-2:0]  acc;
    logic [N-1:0]  shifted;
    logic [CW-1:0] count;
    logic          borrow_q;
    logic          borrow_next;
    logic          diff;
    logic          a_msb;
    logic          b_msb;

    subtrator_completo u_cell (
        .a          (a_sr[0]),
        .b          (b_sr[0]),
        .borrow_in  (borrow_q),
        .borrow_out (borrow_next),
        .diff       (diff)
    );

    // acc holds the N-1 earlier difference bits; with the current bit on top it is the full word.
    assign shifted = {diff, acc};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Handshake: start is a request that is only accepted in IDLE or DONE (a and b are
    // captured on that edge); done is a one-cycle pulse and the outputs hold until the next done.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (count == LAST) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    next_state = ST_RUN;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            acc        <= '0;
            count      <= '0;
            borrow_q   <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            result     <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else if (load) begin
            a_sr     <= a;
            b_sr     <= b;
            borrow_q <= 1'b0;
            count    <= '0;
            a_msb    <= a[N-1];
            b_msb    <= b[N-1];
        end else if (step) begin
            a_sr     <= a_sr >> 1;
            b_sr     <= b_sr >> 1;
            acc      <= shifted[N-1:1];
            borrow_q <= borrow_next;
            count    <= count + CW'(1);
            if (count == LAST) begin
                result     <= shifted;
                borrow_out <= borrow_next;
                overflow   <= (a_msb ^ b_msb) & (diff ^ a_msb);
                zero       <= ~|shifted;
            end
        end
    end

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial: cycle-level reference model plus
// directed cases with literal expectations and a randomized scoreboard run.
module tb_subtrator_serial;

    localparam int N = 8;
    localparam int W = N + 3;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         borrow_out;
    logic         overflow;
    logic         zero;
    logic [1:0]   st;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    logic [W-1:0] exp_q[$];

    subtrator_serial #(.N(N)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .a          (a_in),
        .b          (b_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .zero       (zero),
        .state      (st)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {overflow, borrow, zero, result} from plain arithmetic.
    function automatic logic [W-1:0] model_pack(input logic [N-1:0] x, input logic [N-1:0] y);
        int d;
        logic [N-1:0] r;
        logic bo;
        logic ov;
        r  = x - y;
        bo = (x < y);
        d  = int'($signed(x)) - int'($signed(y));
        ov = (d > (2 ** (N - 1)) - 1) || (d < -(2 ** (N - 1)));
        return {ov, bo, (r == '0), r};
    endfunction

    // Reference model: an accepted start runs for N busy cycles, then one done cycle.
    int           m_left;
    logic         m_done;
    logic [W-1:0] p_pack;
    logic [W-1:0] m_pack;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            p_pack <= '0;
            m_pack <= '0;
        end else begin
            m_done <= (m_left == 1);
            if (m_left == 1)
                m_pack <= p_pack;
            if (m_left != 0) begin
                m_left <= m_left - 1;
            end else if (start) begin
                m_left <= N;
                p_pack <= model_pack(a_in, b_in);
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_left != 0));
            check("done", 32'(done), 32'(m_done));
            check("state", 32'(st), (m_left != 0) ? 32'd1 : (m_done ? 32'd2 : 32'd0));
            check("result", 32'(result), 32'(m_pack[N-1:0]));
            check("flags", 32'({overflow, borrow_out, zero}), 32'(m_pack[N+2:N]));
        end
    end

    // driver: issue one operation from a negedge, return at the negedge where done is seen
    task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y);
        int lat;
        logic [W-1:0] e;
        a_in  = x;
        b_in  = y;
        start = 1'b1;
        exp_q.push_back(model_pack(x, y));
        @(negedge clock);
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check("latency", 32'(lat), 32'(N + 1));
        e = exp_q.pop_front();
        check("sb_result", 32'(result), 32'(e[N-1:0]));
        check("sb_flags", 32'({overflow, borrow_out, zero}), 32'(e[N+2:N]));
    endtask

    task automatic check_outs(input string tag, input logic [N-1:0] r, input logic bo,
                              input logic ov, input logic z);
        check({tag, "_result"}, 32'(result), 32'(r));
        check({tag, "_borrow"}, 32'(borrow_out), 32'(bo));
        check({tag, "_overflow"}, 32'(overflow), 32'(ov));
        check({tag, "_zero"}, 32'(zero), 32'(z));
    endtask

    initial begin
        int n_done;
        int done_at;
        int gap;
        logic [N-1:0] rx;
        logic [N-1:0] ry;

        reset_n = 1'b0;
        start   = 1'b0;
        a_in    = '0;
        b_in    = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(st), 32'd0);
        check_outs("rst", 8'h00, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        @(negedge clock);

        // directed cases with hand-computed results
        do_op(8'd5, 8'd3);
        check("t1_done", 32'(done), 32'd1);
        check_outs("t1", 8'h02, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        do_op(8'd3, 8'd5);
        check_outs("t2", 8'hFE, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        do_op(8'h80, 8'h01);
        check_outs("t3", 8'h7F, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        do_op(8'h2A, 8'h2A);
        check_outs("t4", 8'h00, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clock);
        check("t4_done_low", 32'(done), 32'd0);
        check_outs("t4_hold", 8'h00, 1'b0, 1'b0, 1'b1);

        // start during RUN ignored, operand changes during RUN ignored
        a_in    = 8'h7F;
        b_in    = 8'h80;
        start   = 1'b1;
        n_done  = 0;
        done_at = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clock);
            start = (i == 3);
            if (i == 3) begin
                a_in = 8'h01;
                b_in = 8'h02;
            end
            if (i == 5) begin
                a_in = 8'hC3;
                b_in = 8'h11;
            end
            if (done === 1'b1) begin
                n_done++;
                done_at = i;
            end
        end
        check("t5_single_done", 32'(n_done), 32'd1);
        check("t5_done_at", 32'(done_at), 32'(N + 1));
        check_outs("t5", 8'hFF, 1'b1, 1'b1, 1'b0);

        // reset in the middle of RUN
        a_in  = 8'd9;
        b_in  = 8'd4;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("t6_busy_before", 32'(busy), 32'd1);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check_outs("t6", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        do_op(8'h07, 8'h07);
        check_outs("t6_after", 8'h00, 1'b0, 1'b0, 1'b1);

        // back-to-back: second start in the DONE cycle
        @(negedge clock);
        do_op(8'h64, 8'h0A);
        check_outs("b2b_first", 8'h5A, 1'b0, 1'b0, 1'b0);
        do_op(8'h0A, 8'h64);
        check_outs("b2b_second", 8'hA6, 1'b1, 1'b0, 1'b0);

        // randomized run against the scoreboard
        for (int k = 0; k < 1000; k++) begin
            rx = N'($urandom());
            ry = N'($urandom());
            case ($urandom_range(0, 9))
                0: ry = rx;
                1: rx = '0;
                2: ry = '1;
                3: begin rx = 8'h80; ry = N'($urandom_range(1, 127)); end
                default: ;
            endcase
            do_op(rx, ry);
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clock);
        end

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
